// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the datapath (master) and data_memory_ctrl (slave).
interface data_memory_ctrl_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_signed, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with sized, optionally sign-extended loads and byte-masked stores.
// Optional power-up clear of the array is built when DATA_MEMORY_CTRL_CLEAR_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; stores commit on the accepting edge
// ST_WAIT  | load in flight, cnt_q counts down to the response
// ST_RESP  | response held on the bus until resp_ready
// ST_CLEAR | (optional) zeroing one word per cycle after reset
module data_memory_ctrl #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 64,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   data_memory_ctrl_if.slave  bus
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
      ,
      ST_CLEAR
`endif
   } state_t;

`ifdef DATA_MEMORY_CTRL_CLEAR_EN
   localparam state_t RST_STATE = ST_CLEAR;
`else
   localparam state_t RST_STATE = ST_IDLE;
`endif

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
   logic [IDX_W-1:0]    clr_q, clr_d;
`endif

   logic [OFF_W-1:0]    off;
   logic [IDX_W-1:0]    widx;
   logic                addr_hi_nz, misaligned, size_bad, req_err;
   logic                accept, wr_en;
   logic [DATA_W-1:0]   rd_word, shifted, lmask, ld_data, wdata_sh;
   logic [NB-1:0]       bmask, be;
   logic                sgn_bit;

   assign off        = bus.req_addr[OFF_W-1:0];
   assign widx       = bus.req_addr[OFF_W +: IDX_W];
   // Any set bit above the index field is out of range; no wrap-around.
   assign addr_hi_nz = |bus.req_addr[ADDR_W-1:OFF_W+IDX_W];
   assign size_bad   = (bus.req_size == 2'd3) && (DATA_W != 64);

   always_comb begin
      misaligned = 1'b0;
      case (bus.req_size)
         2'd1:    misaligned = off[0];
         2'd2:    misaligned = |off[1:0];
         2'd3:    misaligned = |off;
         default: misaligned = 1'b0;
      endcase
   end

   assign req_err = misaligned || addr_hi_nz || size_bad;

   assign bus.req_ready  = (state_q == ST_IDLE) && !rst;
   assign accept         = bus.req_valid && bus.req_ready;
   assign wr_en          = accept && bus.req_write && !req_err;

   assign rd_word  = mem_q[widx];
   assign shifted  = rd_word >> {off, 3'b000};
   assign wdata_sh = bus.req_wdata << {off, 3'b000};
   assign be       = bmask << off;

   always_comb begin
      lmask   = '0;
      bmask   = '0;
      sgn_bit = 1'b0;
      case (bus.req_size)
         2'd0: begin
            lmask[7:0] = '1;
            bmask[0]   = 1'b1;
            sgn_bit    = shifted[7];
         end
         2'd1: begin
            lmask[15:0] = '1;
            bmask[1:0]  = '1;
            sgn_bit     = shifted[15];
         end
         2'd2: begin
            lmask[31:0] = '1;
            bmask[3:0]  = '1;
            sgn_bit     = shifted[31];
         end
         default: begin
            lmask = '1;
            bmask = '1;
         end
      endcase
      ld_data = (shifted & lmask) | ({DATA_W{sgn_bit && bus.req_signed}} & ~lmask);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
      clr_d   = clr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               err_d   = req_err;
               rdata_d = (bus.req_write || req_err) ? '0 : ld_data;
               if (bus.req_write || req_err || RD_LAT == 1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(RD_LAT - 1);
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) state_d = ST_IDLE;
         end
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
         ST_CLEAR: begin
            clr_d = clr_q + IDX_W'(1);
            if (clr_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
         clr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
         clr_q   <= clr_d;
`endif
      end
   end

   // Array has no reset; writes only happen on an accepting edge (or while clearing).
   always_ff @(posedge clk) begin
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
      if (state_q == ST_CLEAR && !rst) begin
         mem_q[clr_q] <= '0;
      end else
`endif
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem_q[widx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
         end
      end
   end

   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed-vector bench for data_memory_ctrl (DATA_W=64, DEPTH=64, RD_LAT=3).
module tb_data_memory_ctrl;
   localparam int RD_LAT = 3;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   data_memory_ctrl_if #(.DATA_W(64), .ADDR_W(64)) bus ();

   data_memory_ctrl #(
      .DATA_W(64), .DEPTH(64), .ADDR_W(64), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic w, input logic [63:0] addr, input logic [1:0] sz,
                            input logic sgn, input logic [63:0] wd, output int lat);
      int t;
      @(negedge clk);
      bus.req_write  = w;
      bus.req_addr   = addr;
      bus.req_size   = sz;
      bus.req_signed = sgn;
      bus.req_wdata  = wd;
      bus.req_valid  = 1'b1;
      t = 0;
      while (!bus.req_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) begin
         chk("ready_timeout", 64'(bus.req_ready), 64'd1);
         bus.req_valid = 1'b0;
         lat = -1;
         return;
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.resp_valid) break;
      end
      if (!bus.resp_valid) begin
         chk("resp_timeout", 64'(bus.resp_valid), 64'd1);
         lat = -1;
      end
   endtask

   task automatic take_resp(output logic [63:0] rd, output logic err);
      rd = bus.resp_rdata;
      err = bus.resp_err;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
   endtask

   task automatic xact(input string tag, input logic w, input logic [63:0] addr,
                       input logic [1:0] sz, input logic sgn, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err);
      int lat;
      logic [63:0] rd;
      logic e;
      start_req(w, addr, sz, sgn, wd, lat);
      if (lat < 0) return;
      take_resp(rd, e);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, 64'(e), 64'(exp_err));
      chk({tag, "_lat"}, 64'(lat), (w || exp_err) ? 64'd1 : 64'(RD_LAT));
   endtask

   task automatic wait_ready_after_reset(input string tag);
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
      int n;
      n = 0;
      while (!bus.req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_clear_cycles"}, 64'(n), 64'd64);
`else
      #1 chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      logic seen;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b0;
      rst = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
      chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
      rst = 1'b0;
      wait_ready_after_reset("boot");

`ifdef DATA_MEMORY_CTRL_CLEAR_EN
      xact("clr_ld10", 0, 64'h10, 2'd3, 0, 64'h0, 64'h0, 0);
      xact("clr_ld1f8", 0, 64'h1F8, 2'd3, 0, 64'h0, 64'h0, 0);
`endif

      xact("st_dw0",   1, 64'h0,  2'd3, 0, 64'hCAFEBABE_DEADBEEF, 64'h0, 0);
      xact("st_dw10",  1, 64'h10, 2'd3, 0, 64'h11223344_55667788, 64'h0, 0);
      xact("ld_dw10",  0, 64'h10, 2'd3, 0, 64'h0, 64'h11223344_55667788, 0);
      xact("st_b13",   1, 64'h13, 2'd0, 0, 64'hF0, 64'h0, 0);
      xact("ld_dw10b", 0, 64'h10, 2'd3, 0, 64'h0, 64'h11223344_F0667788, 0);
      xact("ld_b13s",  0, 64'h13, 2'd0, 1, 64'h0, 64'hFFFFFFFF_FFFFFFF0, 0);
      xact("ld_b13u",  0, 64'h13, 2'd0, 0, 64'h0, 64'h00000000_000000F0, 0);
      xact("ld_h10s",  0, 64'h10, 2'd1, 1, 64'h0, 64'h00000000_00007788, 0);
      xact("ld_h12s",  0, 64'h12, 2'd1, 1, 64'h0, 64'hFFFFFFFF_FFFFF066, 0);
      xact("ld_w10s",  0, 64'h10, 2'd2, 1, 64'h0, 64'hFFFFFFFF_F0667788, 0);
      xact("ld_w10u",  0, 64'h10, 2'd2, 0, 64'h0, 64'h00000000_F0667788, 0);
      xact("ld_w14s",  0, 64'h14, 2'd2, 1, 64'h0, 64'h00000000_11223344, 0);
      xact("ld_dw0s",  0, 64'h0,  2'd3, 1, 64'h0, 64'hCAFEBABE_DEADBEEF, 0);

      xact("ld_w12_mis",  0, 64'h12, 2'd2, 0, 64'h0, 64'h0, 1);
      xact("st_h11_mis",  1, 64'h11, 2'd1, 0, 64'hAAAA, 64'h0, 1);
      xact("ld_dw14_mis", 0, 64'h14, 2'd3, 0, 64'h0, 64'h0, 1);
      xact("ld_dw10_post_mis", 0, 64'h10, 2'd3, 0, 64'h0, 64'h11223344_F0667788, 0);

      xact("st_oor200", 1, 64'h200, 2'd3, 0, 64'h01234567_89ABCDEF, 64'h0, 1);
      xact("ld_oor200", 0, 64'h200, 2'd3, 0, 64'h0, 64'h0, 1);
      xact("ld_dw0_post_oor", 0, 64'h0, 2'd3, 0, 64'h0, 64'hCAFEBABE_DEADBEEF, 0);
      xact("st_oor_msb", 1, 64'h80000000_00000010, 2'd3, 0, 64'h0F0F0F0F_0F0F0F0F, 64'h0, 1);
      xact("ld_dw10_post_msb", 0, 64'h10, 2'd3, 0, 64'h0, 64'h11223344_F0667788, 0);

      xact("st_dw18", 1, 64'h18, 2'd3, 0, 64'h0, 64'h0, 0);
      xact("st_w18",  1, 64'h18, 2'd2, 0, 64'hAAAAAAAA_89ABCDEF, 64'h0, 0);
      xact("st_h1e",  1, 64'h1E, 2'd1, 0, 64'h00000000_FFFF1234, 64'h0, 0);
      xact("ld_dw18", 0, 64'h18, 2'd3, 0, 64'h0, 64'h12340000_89ABCDEF, 0);

      xact("st_top",    1, 64'h1F8, 2'd3, 0, 64'h88776655_44332211, 64'h0, 0);
      xact("ld_b1ffs",  0, 64'h1FF, 2'd0, 1, 64'h0, 64'hFFFFFFFF_FFFFFF88, 0);
      xact("ld_h1f8u",  0, 64'h1F8, 2'd1, 0, 64'h0, 64'h00000000_00002211, 0);

      // Response back-pressure: outputs hold while resp_ready is low.
      start_req(0, 64'h10, 2'd3, 0, 64'h0, lat);
      chk("hold_lat", 64'(lat), 64'(RD_LAT));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(bus.resp_valid), 64'd1);
         chk("hold_rdata", bus.resp_rdata, 64'h11223344_F0667788);
         chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
      chk("hs_req_ready", 64'(bus.req_ready), 64'd1);
      chk("hs_resp_valid", 64'(bus.resp_valid), 64'd0);

      // Reset while a load is waiting aborts it.
      @(negedge clk);
      bus.req_write = 1'b0;
      bus.req_addr  = 64'h10;
      bus.req_size  = 2'd3;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("abort_req_ready", 64'(bus.req_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_ready_after_reset("abort");
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.resp_valid) seen = 1'b1;
      end
      chk("abort_no_resp", 64'(seen), 64'd0);
`ifdef DATA_MEMORY_CTRL_CLEAR_EN
      xact("ld_dw10_post_rst", 0, 64'h10, 2'd3, 0, 64'h0, 64'h0, 0);
`else
      xact("ld_dw10_post_rst", 0, 64'h10, 2'd3, 0, 64'h0, 64'h11223344_F0667788, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
